jtkicker_romarb: RTL

Four-slot SDRAM read arbiter for the Kicker-family cores. It shares the single SDRAM read port between the main CPU, the sound CPU, the scroll tile fetcher and the object fetcher. Each slot keeps a one-entry tag/data cache, and misses are sequenced through a fixed-priority request FSM. It sits between the game's ROM clients and the SDRAM controller, in the same clock domain as the video and sound logic.

---
 rtl/jtkicker_romarb_pkg.sv | 30 +++
 rtl/jtkicker_romarb_cache.sv | 75 +++++++
 rtl/jtkicker_romarb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtkicker_romarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtkicker_romarb_pkg
// Brief    : Shared types and constants for the Kicker SDRAM read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package jtkicker_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_DST = 2'd2,
        WAIT_RDY = 2'd3
    } state_t;

    localparam int NSLOTS    = 4;
    localparam int SLOT_ID_W = 2;
    localparam int BYTE_DW   = 8;
    localparam int LONG_DW   = 32;
    localparam int SDRAM_AW  = 22;
    localparam int SDRAM_DW  = 16;
    localparam int TAG_W     = 16;

    // Slots 2 and 3 are the 32-bit fetchers.
    function automatic logic is_long_slot(input logic [SLOT_ID_W-1:0] id);
        return id[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtkicker_romarb_cache.sv
`default_nettype none
// ============================================================================
// Module   : jtkicker_romarb_cache
// Brief    : One-entry tag/data cache for a single ROM slot.
// Revision : 1.0 - initial release
// ============================================================================
module jtkicker_romarb_cache
    import jtkicker_romarb_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                cs,
    input  logic [AW-1:0]       addr,
    input  logic                tag_we,
    input  logic [AW-1:0]       tag_in,
    input  logic                load_lo,
    input  logic                load_hi,
    input  logic [SDRAM_DW-1:0] din,
    output logic                ok,
    output logic [DW-1:0]       dout
);

    logic [AW-1:0] r_tag;
    logic          r_valid;
    logic [DW-1:0] r_data;

    assign ok   = cs & r_valid & ~clr & (addr == r_tag);
    assign dout = r_data;

    // A low-half load means the entry is being replaced, so it stops hitting
    // until the tag write lands together with the final data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (clr) begin
            r_valid <= 1'b0;
        end else if (tag_we) begin
            r_valid <= 1'b1;
            r_tag   <= tag_in;
        end else if (load_lo) begin
            r_valid <= 1'b0;
        end
    end

    generate
        if (DW == BYTE_DW) begin : g_byte
            logic w_unused_hi;
            assign w_unused_hi = load_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (load_lo) begin
                    r_data <= tag_in[0] ? din[15:8] : din[7:0];
                end
            end
        end else begin : g_long
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else begin
                    if (load_lo) r_data[DW/2-1:0]  <= din;
                    if (load_hi) r_data[DW-1:DW/2] <= din;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/jtkicker_romarb.sv
`default_nettype none
// ============================================================================
// Module   : jtkicker_romarb
// Brief    : Four-slot cached SDRAM read arbiter with fixed priority (slot 0 first).
// Revision : 1.0 - initial release
// ============================================================================
module jtkicker_romarb
    import jtkicker_romarb_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] SLOT0_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] SLOT2_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] SLOT3_OFFSET = 22'h0
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,

    input  logic                slot0_cs,
    input  logic                slot1_cs,
    input  logic                slot2_cs,
    input  logic                slot3_cs,
    input  logic [15:0]         slot0_addr,
    input  logic [13:0]         slot1_addr,
    input  logic [14:0]         slot2_addr,
    input  logic [14:0]         slot3_addr,
    output logic                slot0_ok,
    output logic                slot1_ok,
    output logic                slot2_ok,
    output logic                slot3_ok,
    output logic [7:0]          slot0_dout,
    output logic [7:0]          slot1_dout,
    output logic [31:0]         slot2_dout,
    output logic [31:0]         slot3_dout,

    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [SDRAM_DW-1:0] data_read
);

    state_t                r_state;
    state_t                w_next;
    logic [SLOT_ID_W-1:0]  r_slot;
    logic [TAG_W-1:0]      r_tag;
    logic [SDRAM_AW-1:0]   r_sdram_addr;

    logic [NSLOTS-1:0]     w_cs;
    logic [NSLOTS-1:0]     w_ok;
    logic [NSLOTS-1:0]     w_miss;
    logic [NSLOTS-1:0]     w_load_lo;
    logic [NSLOTS-1:0]     w_load_hi;
    logic [NSLOTS-1:0]     w_tag_we;
    logic [SLOT_ID_W-1:0]  w_grant_id;
    logic [TAG_W-1:0]      w_grant_tag;
    logic [SDRAM_AW-1:0]   w_grant_sdram;
    logic [14:0]           w_addr2;
    logic [14:0]           w_addr3;
    logic                  w_unused;

    // Long-word slots address 16-bit words in pairs; bit 0 plays no part.
    assign w_addr2  = {slot2_addr[14:1], 1'b0};
    assign w_addr3  = {slot3_addr[14:1], 1'b0};
    assign w_unused = slot2_addr[0] ^ slot3_addr[0];

    assign w_cs   = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign w_miss = w_cs & ~w_ok & {NSLOTS{~downloading}};

    assign slot0_ok = w_ok[0];
    assign slot1_ok = w_ok[1];
    assign slot2_ok = w_ok[2];
    assign slot3_ok = w_ok[3];

    assign sdram_req  = (r_state == WAIT_ACK) && !downloading;
    assign sdram_addr = r_sdram_addr;

    always_comb begin
        w_grant_id = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (w_miss[i]) w_grant_id = i[SLOT_ID_W-1:0];
        end
    end

    always_comb begin
        w_grant_tag   = '0;
        w_grant_sdram = '0;
        case (w_grant_id)
            2'd0: begin
                w_grant_tag   = slot0_addr;
                w_grant_sdram = SLOT0_OFFSET + {7'd0, slot0_addr[15:1]};
            end
            2'd1: begin
                w_grant_tag   = {2'b00, slot1_addr};
                w_grant_sdram = SLOT1_OFFSET + {9'd0, slot1_addr[13:1]};
            end
            2'd2: begin
                w_grant_tag   = {1'b0, w_addr2};
                w_grant_sdram = SLOT2_OFFSET + {7'd0, w_addr2};
            end
            default: begin
                w_grant_tag   = {1'b0, w_addr3};
                w_grant_sdram = SLOT3_OFFSET + {7'd0, w_addr3};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_slot       <= '0;
            r_tag        <= '0;
            r_sdram_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == WAIT_ACK) begin
                r_slot       <= w_grant_id;
                r_tag        <= w_grant_tag;
                r_sdram_addr <= w_grant_sdram;
            end
        end
    end

    // Strobes always target the latched slot, so a client that moves its
    // address mid-transfer still gets the data stored under the old tag.
    always_comb begin
        w_next    = r_state;
        w_load_lo = '0;
        w_load_hi = '0;
        w_tag_we  = '0;
        if (downloading) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_miss) w_next = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (sdram_ack) w_next = WAIT_DST;
                end
                WAIT_DST: begin
                    if (data_dst) begin
                        w_load_lo[r_slot] = 1'b1;
                        if (is_long_slot(r_slot)) begin
                            if (data_rdy) begin
                                w_load_hi[r_slot] = 1'b1;
                                w_tag_we[r_slot]  = 1'b1;
                                w_next            = IDLE;
                            end else begin
                                w_next = WAIT_RDY;
                            end
                        end else begin
                            w_tag_we[r_slot] = 1'b1;
                            w_next           = data_rdy ? IDLE : WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (data_rdy) begin
                        if (is_long_slot(r_slot)) begin
                            w_load_hi[r_slot] = 1'b1;
                            w_tag_we[r_slot]  = 1'b1;
                        end
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    jtkicker_romarb_cache #(.AW(16), .DW(BYTE_DW)) u_cache0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .cs      (slot0_cs),
        .addr    (slot0_addr),
        .tag_we  (w_tag_we[0]),
        .tag_in  (r_tag),
        .load_lo (w_load_lo[0]),
        .load_hi (w_load_hi[0]),
        .din     (data_read),
        .ok      (w_ok[0]),
        .dout    (slot0_dout)
    );

    jtkicker_romarb_cache #(.AW(14), .DW(BYTE_DW)) u_cache1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .cs      (slot1_cs),
        .addr    (slot1_addr),
        .tag_we  (w_tag_we[1]),
        .tag_in  (r_tag[13:0]),
        .load_lo (w_load_lo[1]),
        .load_hi (w_load_hi[1]),
        .din     (data_read),
        .ok      (w_ok[1]),
        .dout    (slot1_dout)
    );

    jtkicker_romarb_cache #(.AW(15), .DW(LONG_DW)) u_cache2 (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .cs      (slot2_cs),
        .addr    (w_addr2),
        .tag_we  (w_tag_we[2]),
        .tag_in  (r_tag[14:0]),
        .load_lo (w_load_lo[2]),
        .load_hi (w_load_hi[2]),
        .din     (data_read),
        .ok      (w_ok[2]),
        .dout    (slot2_dout)
    );

    jtkicker_romarb_cache #(.AW(15), .DW(LONG_DW)) u_cache3 (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .cs      (slot3_cs),
        .addr    (w_addr3),
        .tag_we  (w_tag_we[3]),
        .tag_in  (r_tag[14:0]),
        .load_lo (w_load_lo[3]),
        .load_hi (w_load_hi[3]),
        .din     (data_read),
        .ok      (w_ok[3]),
        .dout    (slot3_dout)
    );

endmodule
`default_nettype wire
